riscv_cpu: RTL and testbench

RISCV_CPU -- requirements
Module: riscv_cpu

---
 rtl/riscv_cpu.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_riscv_cpu.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_cpu.sv
// riscv_cpu: 5-stage in-order RV32I-subset pipeline (IF, ID, EX, MEM, WB)
// with full forwarding, one-cycle load-use stall and predict-not-taken beq.
// Submodules are instantiated as imem, dmem, regfile and if_stage.

// Instruction memory: combinational fetch port plus a loader write port.
module riscv_imem (
  input  logic        clock,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] IMem [0:255];

  // Loader write port; the core ties it off and never writes its own code
  always_ff @(posedge clock) begin
    if (we) IMem[waddr] <= wdata;
  end

  assign rdata = IMem[raddr];
endmodule

// Data memory: combinational word read, write on the rising edge ending MEM.
module riscv_dmem (
  input  logic        clock,
  input  logic [7:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] DMem [0:255];

  // Store write; contents survive reset so a preload is never disturbed
  always_ff @(posedge clock) begin
    if (we) DMem[addr] <= wdata;
  end

  assign rdata = DMem[addr];
endmodule

// Register file: two read ports with WB write-through, x0 hard-wired to zero.
module riscv_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] Regs [0:31];

  // Register write in WB; reset clears every register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) Regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      Regs[wa] <= wd;
    end
  end

  // Read ports: a same-cycle WB write to the read register is bypassed
  always_comb begin
    rd1 = Regs[ra1];
    rd2 = Regs[ra2];
    if (we && (wa == ra1)) rd1 = wd;
    if (we && (wa == ra2)) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end
endmodule

// Fetch PC: +4 per unstalled cycle, redirect on taken branch, 1 KB wrap.
module riscv_if_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);
  localparam logic [31:0] PC_MASK = 32'h0000_03FF;

  logic [31:0] PC;
  logic [31:0] pc_d;

  // Next PC: a redirect wins over a stall so a flush is never lost
  always_comb begin
    pc_d = PC;
    if (redirect)   pc_d = redirect_pc & PC_MASK;
    else if (!stall) pc_d = (PC + 32'd4) & PC_MASK;
  end

  // PC register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) PC <= '0;
    else        PC <= pc_d;
  end

  assign pc = PC;
endmodule

// Pipeline top: stage registers, decode, hazard detection, forwarding, ALU.
module riscv_cpu (
  input logic clock,
  input logic reset
);
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src_imm;
    alu_op_t alu_op;
  } ctrl_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- IF ----------------
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;

  riscv_if_stage if_stage (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (flush),
    .redirect_pc (branch_target),
    .pc          (if_pc)
  );

  riscv_imem imem (
    .clock (clock),
    .raddr (if_pc[9:2]),
    .rdata (if_instr),
    .we    (1'b0),
    .waddr (8'd0),
    .wdata (32'd0)
  );

  // ---------------- pipeline registers ----------------
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;

  ctrl_t       idex_ctrl_q, idex_ctrl_d;
  logic [31:0] idex_pc_q, idex_pc_d;
  logic [31:0] idex_rs1_val_q, idex_rs1_val_d;
  logic [31:0] idex_rs2_val_q, idex_rs2_val_d;
  logic [31:0] idex_imm_q, idex_imm_d;
  logic [4:0]  idex_rs1_q, idex_rs1_d;
  logic [4:0]  idex_rs2_q, idex_rs2_d;
  logic [4:0]  idex_rd_q, idex_rd_d;

  logic        exmem_reg_write_q, exmem_reg_write_d;
  logic        exmem_mem_read_q, exmem_mem_read_d;
  logic        exmem_mem_write_q, exmem_mem_write_d;
  logic [4:0]  exmem_rd_q, exmem_rd_d;
  logic [31:0] exmem_alu_q, exmem_alu_d;
  logic [31:0] exmem_store_q, exmem_store_d;

  logic        memwb_reg_write_q, memwb_reg_write_d;
  logic        memwb_mem_read_q, memwb_mem_read_d;
  logic [4:0]  memwb_rd_q, memwb_rd_d;
  logic [31:0] memwb_alu_q, memwb_alu_d;
  logic [31:0] memwb_load_q, memwb_load_d;

  // IF/ID next value: flush inserts a NOP, stall holds the fetched word
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (flush) begin
      ifid_instr_d = NOP;
      ifid_pc_d    = '0;
    end else if (!stall) begin
      ifid_instr_d = if_instr;
      ifid_pc_d    = if_pc;
    end
  end

  // ---------------- ID ----------------
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] imm_i, imm_s, imm_b;
  ctrl_t       id_ctrl;
  logic [31:0] id_imm;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_rs1_val, id_rs2_val;
  logic [31:0] wb_data;

  assign id_opcode = ifid_instr_q[6:0];
  assign id_rd     = ifid_instr_q[11:7];
  assign id_funct3 = ifid_instr_q[14:12];
  assign id_rs1    = ifid_instr_q[19:15];
  assign id_rs2    = ifid_instr_q[24:20];
  assign id_funct7 = ifid_instr_q[31:25];

  assign imm_i = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
  assign imm_s = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
  assign imm_b = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                  ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};

  // Decode: anything outside the supported subset leaves control at zero (NOP)
  always_comb begin
    id_ctrl    = '0;
    id_imm     = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    case (id_opcode)
      7'b0000011: begin // lw
        if (id_funct3 == 3'b010) begin
          id_ctrl.reg_write   = 1'b1;
          id_ctrl.mem_read    = 1'b1;
          id_ctrl.alu_src_imm = 1'b1;
          id_imm              = imm_i;
          id_use_rs1          = 1'b1;
        end
      end
      7'b0100011: begin // sw
        if (id_funct3 == 3'b010) begin
          id_ctrl.mem_write   = 1'b1;
          id_ctrl.alu_src_imm = 1'b1;
          id_imm              = imm_s;
          id_use_rs1          = 1'b1;
          id_use_rs2          = 1'b1;
        end
      end
      7'b0010011: begin // addi / andi / ori
        id_imm = imm_i;
        case (id_funct3)
          3'b000:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_ADD; end
          3'b111:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_AND; end
          3'b110:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_OR;  end
          default: ;
        endcase
        id_ctrl.alu_src_imm = id_ctrl.reg_write;
        id_use_rs1          = id_ctrl.reg_write;
      end
      7'b0110011: begin // add / sub / and / or / slt
        if (id_funct7 == 7'b0000000) begin
          case (id_funct3)
            3'b000:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_ADD; end
            3'b111:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_AND; end
            3'b110:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_OR;  end
            3'b010:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SLT; end
            default: ;
          endcase
        end else if ((id_funct7 == 7'b0100000) && (id_funct3 == 3'b000)) begin
          id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_op    = ALU_SUB;
        end
        id_use_rs1 = id_ctrl.reg_write;
        id_use_rs2 = id_ctrl.reg_write;
      end
      7'b1100011: begin // beq
        if (id_funct3 == 3'b000) begin
          id_ctrl.branch = 1'b1;
          id_imm         = imm_b;
          id_use_rs1     = 1'b1;
          id_use_rs2     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  riscv_regfile regfile (
    .clock (clock),
    .reset (reset),
    .ra1   (id_rs1),
    .ra2   (id_rs2),
    .rd1   (id_rs1_val),
    .rd2   (id_rs2_val),
    .we    (memwb_reg_write_q),
    .wa    (memwb_rd_q),
    .wd    (wb_data)
  );

  // Load-use detection: a load in EX whose rd is a source of the ID instruction
  always_comb begin
    stall = 1'b0;
    if (idex_ctrl_q.mem_read && (idex_rd_q != 5'd0)) begin
      if ((id_use_rs1 && (id_rs1 == idex_rd_q)) ||
          (id_use_rs2 && (id_rs2 == idex_rd_q)))
        stall = 1'b1;
    end
  end

  // ID/EX next value: stall or flush turn the slot into a bubble
  always_comb begin
    idex_ctrl_d    = id_ctrl;
    idex_pc_d      = ifid_pc_q;
    idex_rs1_val_d = id_rs1_val;
    idex_rs2_val_d = id_rs2_val;
    idex_imm_d     = id_imm;
    idex_rs1_d     = id_rs1;
    idex_rs2_d     = id_rs2;
    idex_rd_d      = id_rd;
    if (flush || stall) begin
      idex_ctrl_d    = '0;
      idex_pc_d      = '0;
      idex_rs1_val_d = '0;
      idex_rs2_val_d = '0;
      idex_imm_d     = '0;
      idex_rs1_d     = '0;
      idex_rs2_d     = '0;
      idex_rd_d      = '0;
    end
  end

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_result;

  // Operand forwarding: EX/MEM beats MEM/WB beats the value read in ID
  always_comb begin
    fwd_a = idex_rs1_val_q;
    fwd_b = idex_rs2_val_q;
    if (exmem_reg_write_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == idex_rs1_q))
      fwd_a = exmem_alu_q;
    else if (memwb_reg_write_q && (memwb_rd_q != 5'd0) && (memwb_rd_q == idex_rs1_q))
      fwd_a = wb_data;
    if (exmem_reg_write_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == idex_rs2_q))
      fwd_b = exmem_alu_q;
    else if (memwb_reg_write_q && (memwb_rd_q != 5'd0) && (memwb_rd_q == idex_rs2_q))
      fwd_b = wb_data;
  end

  assign alu_b = idex_ctrl_q.alu_src_imm ? idex_imm_q : fwd_b;

  // ALU: 32-bit wrap-around arithmetic, signed set-less-than
  always_comb begin
    alu_result = fwd_a + alu_b;
    case (idex_ctrl_q.alu_op)
      ALU_SUB: alu_result = fwd_a - alu_b;
      ALU_AND: alu_result = fwd_a & alu_b;
      ALU_OR:  alu_result = fwd_a | alu_b;
      ALU_SLT: alu_result = {31'd0, ($signed(fwd_a) < $signed(alu_b))};
      default: alu_result = fwd_a + alu_b;
    endcase
  end

  assign flush         = idex_ctrl_q.branch && (fwd_a == fwd_b);
  assign branch_target = idex_pc_q + idex_imm_q;

  // EX/MEM next value
  always_comb begin
    exmem_reg_write_d = idex_ctrl_q.reg_write;
    exmem_mem_read_d  = idex_ctrl_q.mem_read;
    exmem_mem_write_d = idex_ctrl_q.mem_write;
    exmem_rd_d        = idex_rd_q;
    exmem_alu_d       = alu_result;
    exmem_store_d     = fwd_b;
  end

  // ---------------- MEM ----------------
  logic [31:0] mem_rdata;

  riscv_dmem dmem (
    .clock (clock),
    .addr  (exmem_alu_q[9:2]),
    .we    (exmem_mem_write_q),
    .wdata (exmem_store_q),
    .rdata (mem_rdata)
  );

  // MEM/WB next value
  always_comb begin
    memwb_reg_write_d = exmem_reg_write_q;
    memwb_mem_read_d  = exmem_mem_read_q;
    memwb_rd_d        = exmem_rd_q;
    memwb_alu_d       = exmem_alu_q;
    memwb_load_d      = mem_rdata;
  end

  // ---------------- WB ----------------
  assign wb_data = memwb_mem_read_q ? memwb_load_q : memwb_alu_q;

  // Stage registers; reset empties every stage so no in-flight write survives
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ifid_instr_q      <= NOP;
      ifid_pc_q         <= '0;
      idex_ctrl_q       <= '0;
      idex_pc_q         <= '0;
      idex_rs1_val_q    <= '0;
      idex_rs2_val_q    <= '0;
      idex_imm_q        <= '0;
      idex_rs1_q        <= '0;
      idex_rs2_q        <= '0;
      idex_rd_q         <= '0;
      exmem_reg_write_q <= 1'b0;
      exmem_mem_read_q  <= 1'b0;
      exmem_mem_write_q <= 1'b0;
      exmem_rd_q        <= '0;
      exmem_alu_q       <= '0;
      exmem_store_q     <= '0;
      memwb_reg_write_q <= 1'b0;
      memwb_mem_read_q  <= 1'b0;
      memwb_rd_q        <= '0;
      memwb_alu_q       <= '0;
      memwb_load_q      <= '0;
    end else begin
      ifid_instr_q      <= ifid_instr_d;
      ifid_pc_q         <= ifid_pc_d;
      idex_ctrl_q       <= idex_ctrl_d;
      idex_pc_q         <= idex_pc_d;
      idex_rs1_val_q    <= idex_rs1_val_d;
      idex_rs2_val_q    <= idex_rs2_val_d;
      idex_imm_q        <= idex_imm_d;
      idex_rs1_q        <= idex_rs1_d;
      idex_rs2_q        <= idex_rs2_d;
      idex_rd_q         <= idex_rd_d;
      exmem_reg_write_q <= exmem_reg_write_d;
      exmem_mem_read_q  <= exmem_mem_read_d;
      exmem_mem_write_q <= exmem_mem_write_d;
      exmem_rd_q        <= exmem_rd_d;
      exmem_alu_q       <= exmem_alu_d;
      exmem_store_q     <= exmem_store_d;
      memwb_reg_write_q <= memwb_reg_write_d;
      memwb_mem_read_q  <= memwb_mem_read_d;
      memwb_rd_q        <= memwb_rd_d;
      memwb_alu_q       <= memwb_alu_d;
      memwb_load_q      <= memwb_load_d;
    end
  end
endmodule

// File: tb/tb_riscv_cpu.sv
// tb_riscv_cpu: directed program table, timing/reset sequences, and random
// programs checked against an instruction-level interpreter.
module tb_riscv_cpu;
  logic clock = 1'b0;
  logic reset = 1'b0;

  riscv_cpu dut (
    .clock (clock),
    .reset (reset)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] img   [256];
  logic [31:0] dimg  [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [256];

  typedef struct packed {
    logic [3:0]  prog;
    logic        is_mem;
    logic [7:0]  idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %08h, expected %08h", name, actual, expected);
    end else begin
      $display("[TB] ok %s = %08h", name, actual);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  task automatic clear_images();
    for (int i = 0; i < 256; i++) begin
      img[i]  = NOP;
      dimg[i] = '0;
    end
  endtask

  task automatic build_prog(input int id);
    clear_images();
    case (id)
      0: begin
        img[0]  = 32'h00002083; img[1]  = 32'h00108133; img[2]  = 32'h00000013;
        img[3]  = 32'h00202223; img[4]  = 32'h00402183; img[5]  = 32'h00118233;
        img[6]  = 32'h00402423; img[7]  = 32'h00c00293; img[8]  = 32'h0052a023;
        img[9]  = 32'h0002a303; img[10] = 32'h00632223; img[11] = NOP;
        dimg[0] = 32'd5;
      end
      1: begin
        img[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'h13);
        img[1] = enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2);
        img[2] = enc_r(7'd0, 5'd1, 5'd2, 3'b000, 5'd3);
      end
      2: begin
        img[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'h13);
        img[1] = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd1);
      end
      default: begin
        img[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'h13);
        img[1] = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        img[2] = enc_i(12'd9, 5'd0, 3'b000, 5'd2, 7'h13);
        img[3] = enc_i(12'd4, 5'd0, 3'b000, 5'd3, 7'h13);
      end
    endcase
  endtask

  // Hold reset, preload memories, release on a falling edge
  task automatic start_program();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 256; i++) begin
      dut.imem.IMem[i] = img[i];
      dut.dmem.DMem[i] = dimg[i];
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    int          kind;
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    imm  = 12'($urandom);
    kind = $urandom_range(0, 11);
    case (kind)
      0:  return enc_i(imm, rs1, 3'b010, rd, 7'h03);
      1:  return enc_s(imm, rs2, rs1, 3'b010);
      2:  return enc_i(imm, rs1, 3'b000, rd, 7'h13);
      3:  return enc_i(imm, rs1, 3'b111, rd, 7'h13);
      4:  return enc_i(imm, rs1, 3'b110, rd, 7'h13);
      5:  return enc_r(7'h00, rs2, rs1, 3'b000, rd);
      6:  return enc_r(7'h20, rs2, rs1, 3'b000, rd);
      7:  return enc_r(7'h00, rs2, rs1, 3'b111, rd);
      8:  return enc_r(7'h00, rs2, rs1, 3'b110, rd);
      9:  return enc_r(7'h00, rs2, rs1, 3'b010, rd);
      10: return enc_b(13'(4 * $urandom_range(1, 4)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 3'b000);
      default: begin
        case ($urandom_range(0, 5))
          0: return {imm, rs1, 3'b000, rd, 7'h37};             // lui
          1: return enc_s(imm, rs2, rs1, 3'b000);              // sb
          2: return enc_i(imm, rs1, 3'b001, rd, 7'h13);        // slli
          3: return enc_r(7'h01, rs2, rs1, 3'b000, rd);        // mul
          4: return enc_i(imm, rs1, 3'b000, rd, 7'h03);        // lb
          default: return enc_b(13'd8, rs2, rs1, 3'b001);      // bne
        endcase
      end
    endcase
  endfunction

  // Instruction-at-a-time interpreter of the supported subset
  task automatic model_run(input int len);
    int          pc;
    int          steps;
    logic [31:0] ins, a, b, res, addr, imm_i, imm_s, imm_b;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        wr;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = dimg[i];
    pc = 0;
    steps = 0;
    while (pc < len && steps < 400) begin
      ins   = img[pc];
      op    = ins[6:0];
      rd    = ins[11:7];
      f3    = ins[14:12];
      rs1   = ins[19:15];
      rs2   = ins[24:20];
      f7    = ins[31:25];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      a     = m_regs[rs1];
      b     = m_regs[rs2];
      wr    = 1'b0;
      res   = '0;
      pc    = pc + 1;
      if (op == 7'h03 && f3 == 3'b010) begin
        addr = a + imm_i; res = m_mem[addr[9:2]]; wr = 1'b1;
      end else if (op == 7'h23 && f3 == 3'b010) begin
        addr = a + imm_s; m_mem[addr[9:2]] = b;
      end else if (op == 7'h13 && f3 == 3'b000) begin
        res = a + imm_i; wr = 1'b1;
      end else if (op == 7'h13 && f3 == 3'b111) begin
        res = a & imm_i; wr = 1'b1;
      end else if (op == 7'h13 && f3 == 3'b110) begin
        res = a | imm_i; wr = 1'b1;
      end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b000) begin
        res = a + b; wr = 1'b1;
      end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'b000) begin
        res = a - b; wr = 1'b1;
      end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b111) begin
        res = a & b; wr = 1'b1;
      end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b110) begin
        res = a | b; wr = 1'b1;
      end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b010) begin
        res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1;
      end else if (op == 7'h63 && f3 == 3'b000) begin
        if (a == b) pc = pc - 1 + int'($signed(imm_b)) / 4;
      end
      if (wr && rd != 5'd0) m_regs[rd] = res;
      steps++;
    end
  endtask

  initial begin
    int cur_prog;
    int len;
    int bad;

    // Spec-fixed results for the four directed programs
    vecs[0]  = '{4'd0, 1'b0, 8'd1, 32'd5};
    vecs[1]  = '{4'd0, 1'b0, 8'd2, 32'd10};
    vecs[2]  = '{4'd0, 1'b0, 8'd3, 32'd10};
    vecs[3]  = '{4'd0, 1'b0, 8'd4, 32'd15};
    vecs[4]  = '{4'd0, 1'b0, 8'd5, 32'd12};
    vecs[5]  = '{4'd0, 1'b0, 8'd6, 32'd12};
    vecs[6]  = '{4'd0, 1'b1, 8'd0, 32'd5};
    vecs[7]  = '{4'd0, 1'b1, 8'd1, 32'd10};
    vecs[8]  = '{4'd0, 1'b1, 8'd2, 32'd15};
    vecs[9]  = '{4'd0, 1'b1, 8'd3, 32'd12};
    vecs[10] = '{4'd0, 1'b1, 8'd4, 32'd12};
    vecs[11] = '{4'd1, 1'b0, 8'd1, 32'd3};
    vecs[12] = '{4'd1, 1'b0, 8'd2, 32'd6};
    vecs[13] = '{4'd1, 1'b0, 8'd3, 32'd9};
    vecs[14] = '{4'd2, 1'b0, 8'd0, 32'd0};
    vecs[15] = '{4'd2, 1'b0, 8'd1, 32'd0};
    vecs[16] = '{4'd3, 1'b0, 8'd1, 32'd1};
    vecs[17] = '{4'd3, 1'b0, 8'd2, 32'd0};
    vecs[18] = '{4'd3, 1'b0, 8'd3, 32'd4};

    // Reset state
    clear_images();
    start_program();
    run_edges(3);
    reset = 1'b0;
    #1;
    check("reset PC", dut.if_stage.PC, 32'd0);
    check("reset x1", dut.regfile.Regs[1], 32'd0);

    // Directed table
    cur_prog = -1;
    for (int v = 0; v < 19; v++) begin
      if (int'(vecs[v].prog) != cur_prog) begin
        cur_prog = int'(vecs[v].prog);
        build_prog(cur_prog);
        start_program();
        run_edges(cur_prog == 0 ? 500 : 20);
      end
      if (vecs[v].is_mem)
        check($sformatf("prog%0d DMem[%0d]", cur_prog, vecs[v].idx),
              dut.dmem.DMem[vecs[v].idx], vecs[v].exp);
      else
        check($sformatf("prog%0d x%0d", cur_prog, vecs[v].idx),
              dut.regfile.Regs[vecs[v].idx[4:0]], vecs[v].exp);
    end

    // Reset clears registers and PC but leaves DMem intact
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset-hold PC", dut.if_stage.PC, 32'd0);
    check("reset-hold x3", dut.regfile.Regs[3], 32'd0);
    check("reset-hold x2", dut.regfile.Regs[2], 32'd0);

    // Load-use costs exactly one stall cycle: x2 lands on edge 7, not 6
    build_prog(0);
    start_program();
    run_edges(6);
    check("loaduse x2 @6", dut.regfile.Regs[2], 32'd0);
    run_edges(1);
    check("loaduse x2 @7", dut.regfile.Regs[2], 32'd10);

    // Back-to-back ALU forwarding has no stall: x3 lands on edge 7
    build_prog(1);
    start_program();
    run_edges(6);
    check("fwd x3 @6", dut.regfile.Regs[3], 32'd0);
    run_edges(1);
    check("fwd x3 @7", dut.regfile.Regs[3], 32'd9);

    // Reset with a store in EX/MEM and an addi behind it: neither may commit
    clear_images();
    img[0]  = enc_s(12'd12, 5'd0, 5'd0, 3'b010);
    img[1]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
    dimg[3] = 32'h0000_ABCD;
    start_program();
    run_edges(3);
    reset = 1'b0;
    run_edges(3);
    check("abort DMem[3]", dut.dmem.DMem[3], 32'h0000_ABCD);
    check("abort x1", dut.regfile.Regs[1], 32'd0);
    reset = 1'b1;
    run_edges(20);
    check("rerun DMem[3]", dut.dmem.DMem[3], 32'd0);
    check("rerun x1", dut.regfile.Regs[1], 32'd5);

    // Reset after 5 cycles of the load-hazard program, then run to completion
    build_prog(0);
    start_program();
    run_edges(5);
    reset = 1'b0;
    run_edges(2);
    reset = 1'b1;
    run_edges(500);
    check("midreset x1", dut.regfile.Regs[1], 32'd5);
    check("midreset x2", dut.regfile.Regs[2], 32'd10);
    check("midreset x3", dut.regfile.Regs[3], 32'd10);
    check("midreset x4", dut.regfile.Regs[4], 32'd15);
    check("midreset x5", dut.regfile.Regs[5], 32'd12);
    check("midreset x6", dut.regfile.Regs[6], 32'd12);
    check("midreset DMem[0]", dut.dmem.DMem[0], 32'd5);
    check("midreset DMem[1]", dut.dmem.DMem[1], 32'd10);
    check("midreset DMem[2]", dut.dmem.DMem[2], 32'd15);
    check("midreset DMem[3]", dut.dmem.DMem[3], 32'd12);
    check("midreset DMem[4]", dut.dmem.DMem[4], 32'd12);

    // Random programs against the interpreter
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(12, 40);
      for (int i = 0; i < 256; i++) begin
        img[i]  = NOP;
        dimg[i] = $urandom;
      end
      for (int i = 0; i < len; i++) img[i] = gen_instr();
      model_run(len);
      start_program();
      run_edges(3 * len + 12);
      for (int r = 1; r < 32; r++)
        check($sformatf("rnd%0d x%0d", t, r), dut.regfile.Regs[r], m_regs[r]);
      bad = 0;
      for (int i = 255; i >= 0; i--)
        if (dut.dmem.DMem[i] !== m_mem[i]) bad = i;
      check($sformatf("rnd%0d DMem[%0d]", t, bad), dut.dmem.DMem[bad], m_mem[bad]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
